// File: rtl/fb_mem_arbiter.sv
// rtl/fb_mem_arbiter.sv - CPU / video scan-out arbiter for the single-port frame memory
// Optional CPU starvation guard: define FB_ARB_STARVE_GUARD_EN.
module fb_mem_arbiter #(
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 8000,
  parameter int BURST_MAX    = 16,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [ADDR_W-1:0]            cpu_address,
  input  logic [DATA_W/8-1:0]          cpu_byteenable,
  input  logic                         cpu_read,
  input  logic                         cpu_write,
  input  logic [DATA_W-1:0]            cpu_writedata,
  output logic                         cpu_waitrequest,
  output logic [DATA_W-1:0]            cpu_readdata,
  output logic                         cpu_readdatavalid,
  input  logic [ADDR_W-1:0]            vid_address,
  input  logic [$clog2(BURST_MAX):0]   vid_burstcount,
  input  logic                         vid_read,
  output logic                         vid_waitrequest,
  output logic [DATA_W-1:0]            vid_readdata,
  output logic                         vid_readdatavalid,
  output logic [ADDR_W-1:0]            mem_address,
  output logic [DATA_W/8-1:0]          mem_byteenable,
  output logic [DATA_W-1:0]            mem_writedata,
  output logic                         mem_chipselect,
  output logic                         mem_write,
  input  logic [DATA_W-1:0]            mem_readdata
);
  localparam int CNT_W = $clog2(BURST_MAX) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(BURST_MAX);
  localparam logic [CNT_W-1:0]  ONE_CNT   = CNT_W'(1);

  typedef enum logic {S_IDLE, S_VID} state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_count, w_count_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic                r_cpu_rdv, r_vid_rdv;
  logic                w_cpu_req, w_force_cpu;
  logic                w_cpu_grant, w_vid_grant, w_vid_issue;
  logic [CNT_W-1:0]    w_bc;
  logic [ADDR_W-1:0]   w_issue_addr, w_issue_addr_inc;

  assign w_cpu_req        = cpu_read | cpu_write;
  assign w_issue_addr     = (r_state == S_VID) ? r_addr : vid_address;
  assign w_issue_addr_inc = (w_issue_addr == LAST_ADDR) ? '0 : w_issue_addr + ADDR_W'(1);

  always_comb begin
    if (vid_burstcount == '0)         w_bc = ONE_CNT;
    else if (vid_burstcount > MAX_CNT) w_bc = MAX_CNT;
    else                               w_bc = vid_burstcount;
  end

`ifdef FB_ARB_STARVE_GUARD_EN
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_LIMIT);
  logic [STV_W-1:0] r_starve;

  assign w_force_cpu = w_cpu_req && (r_starve == STV_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                             r_starve <= '0;
    else if (w_cpu_grant)                     r_starve <= '0;
    else if (w_cpu_req && r_starve != STV_MAX) r_starve <= r_starve + STV_W'(1);
  end
`else
  assign w_force_cpu = 1'b0;
`endif

  // r_count holds the beats still to issue once in S_VID, including the current one.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_addr_nxt  = r_addr;
    w_cpu_grant = 1'b0;
    w_vid_grant = 1'b0;
    w_vid_issue = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (vid_read && !w_force_cpu) begin
          w_vid_grant = 1'b1;
          w_vid_issue = 1'b1;
          w_count_nxt = w_bc - ONE_CNT;
          w_addr_nxt  = w_issue_addr_inc;
          if (w_bc > ONE_CNT) w_state_nxt = S_VID;
        end else if (w_cpu_req) begin
          w_cpu_grant = 1'b1;
        end
      end
      S_VID: begin
        w_vid_issue = 1'b1;
        w_count_nxt = r_count - ONE_CNT;
        w_addr_nxt  = w_issue_addr_inc;
        if (r_count == ONE_CNT) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign cpu_waitrequest = !(reset_n && w_cpu_grant);
  assign vid_waitrequest = !(reset_n && w_vid_grant);

  always_comb begin
    mem_address    = w_issue_addr;
    mem_byteenable = '1;
    mem_writedata  = cpu_writedata;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    if (reset_n) begin
      if (w_cpu_grant) begin
        mem_address    = cpu_address;
        mem_byteenable = cpu_byteenable;
        mem_chipselect = 1'b1;
        mem_write      = cpu_write;
      end else if (w_vid_issue) begin
        mem_chipselect = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_addr    <= '0;
      r_cpu_rdv <= 1'b0;
      r_vid_rdv <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_addr    <= w_addr_nxt;
      r_cpu_rdv <= w_cpu_grant && cpu_read && !cpu_write;
      r_vid_rdv <= w_vid_issue;
    end
  end

  assign cpu_readdatavalid = r_cpu_rdv;
  assign vid_readdatavalid = r_vid_rdv;
  assign cpu_readdata      = mem_readdata;
  assign vid_readdata      = mem_readdata;

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// tb/tb_fb_mem_arbiter.sv - scoreboard bench for fb_mem_arbiter
module tb_fb_mem_arbiter;
  localparam int AW = 13, DW = 32, DEPTH = 8000, BMAX = 16, SLIM = 8, CW = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [AW-1:0] cpu_address = '0;
  logic [3:0]    cpu_byteenable = '0;
  logic          cpu_read = 1'b0, cpu_write = 1'b0;
  logic [DW-1:0] cpu_writedata = '0;
  logic          cpu_waitrequest, cpu_readdatavalid;
  logic [DW-1:0] cpu_readdata;
  logic [AW-1:0] vid_address = '0;
  logic [CW-1:0] vid_burstcount = '0;
  logic          vid_read = 1'b0;
  logic          vid_waitrequest, vid_readdatavalid;
  logic [DW-1:0] vid_readdata;
  logic [AW-1:0] mem_address;
  logic [3:0]    mem_byteenable;
  logic [DW-1:0] mem_writedata;
  logic          mem_chipselect, mem_write;
  logic [DW-1:0] mem_readdata = '0;

  fb_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .BURST_MAX(BMAX), .STARVE_LIMIT(SLIM)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_address(cpu_address), .cpu_byteenable(cpu_byteenable), .cpu_read(cpu_read),
    .cpu_write(cpu_write), .cpu_writedata(cpu_writedata), .cpu_waitrequest(cpu_waitrequest),
    .cpu_readdata(cpu_readdata), .cpu_readdatavalid(cpu_readdatavalid),
    .vid_address(vid_address), .vid_burstcount(vid_burstcount), .vid_read(vid_read),
    .vid_waitrequest(vid_waitrequest), .vid_readdata(vid_readdata), .vid_readdatavalid(vid_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame memory slave: one-cycle read latency, byte-lane writes.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write)
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) mem[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      mem_readdata <= mem[mem_address];
    end
  end

  logic [DW-1:0] ref_mem [DEPTH];
  typedef struct { logic [31:0] data; int cyc; } exp_t;
  exp_t cpu_q[$];
  exp_t vid_q[$];
  exp_t e_c, e_v;
  int total = 0, bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] be);
    for (int b = 0; b < 4; b++) if (be[b]) o[8*b +: 8] = d[8*b +: 8];
    return o;
  endfunction

  function automatic int beats(input int bc);
    if (bc == 0) return 1;
    if (bc > BMAX) return BMAX;
    return bc;
  endfunction

  // Monitor: pops the scoreboard whenever a valid is presented.
  initial forever begin
    @(negedge clk);
    if (cpu_readdatavalid) begin
      if (cpu_q.size() == 0) begin
        total++; bad++;
        $display("FAIL cpu_unexpected_valid: got valid with data %0h, required none (cycle %0d)", cpu_readdata, cyc);
      end else begin
        e_c = cpu_q.pop_front();
        check("cpu_rdata", cpu_readdata, e_c.data);
        check("cpu_rdv_cycle", cyc, e_c.cyc);
      end
    end
    if (vid_readdatavalid) begin
      if (vid_q.size() == 0) begin
        total++; bad++;
        $display("FAIL vid_unexpected_valid: got valid with data %0h, required none (cycle %0d)", vid_readdata, cyc);
      end else begin
        e_v = vid_q.pop_front();
        check("vid_rdata", vid_readdata, e_v.data);
        check("vid_rdv_cycle", cyc, e_v.cyc);
      end
    end
  end

  // Drivers are entered just after a falling edge; acceptance is sampled 1 unit before the rising edge.
  task automatic cpu_access(input bit wr, input bit rd, input int a, input logic [3:0] be,
                            input logic [31:0] d, output int acc);
    int n = 0;
    cpu_address = AW'(a); cpu_byteenable = be; cpu_writedata = d;
    cpu_write = wr; cpu_read = rd; acc = -1;
    while (acc < 0 && n < 2000) begin
      #4;
      if (!cpu_waitrequest) begin
        acc = cyc;
        if (wr) ref_mem[a] = merge(ref_mem[a], d, be);
        else cpu_q.push_back('{ref_mem[a], cyc + 1});
      end
      @(negedge clk);
      n++;
    end
    cpu_read = 1'b0; cpu_write = 1'b0;
    if (acc < 0) begin
      total++; bad++;
      $display("FAIL cpu_accept_timeout: got no grant in %0d cycles, required a grant", n);
    end
  endtask

  task automatic vid_burst(input int a, input int bc, output int acc);
    int n = 0;
    vid_address = AW'(a); vid_burstcount = CW'(bc); vid_read = 1'b1; acc = -1;
    while (acc < 0 && n < 2000) begin
      #4;
      if (!vid_waitrequest) begin
        acc = cyc;
        for (int i = 0; i < beats(bc); i++)
          vid_q.push_back('{ref_mem[(a + i) % DEPTH], cyc + 1 + i});
      end
      @(negedge clk);
      n++;
    end
    vid_read = 1'b0;
    if (acc < 0) begin
      total++; bad++;
      $display("FAIL vid_accept_timeout: got no grant in %0d cycles, required a grant", n);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((cpu_q.size() != 0 || vid_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check(name, cpu_q.size() + vid_q.size(), 0);
  endtask

  int st, acc_c, acc_v, acc_v0, tmp;

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = DW'(i);
      ref_mem[i] = DW'(i);
    end
    cpu_read = 1'b1; vid_read = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cpu_wait", cpu_waitrequest, 1);
    check("rst_vid_wait", vid_waitrequest, 1);
    check("rst_cpu_rdv", cpu_readdatavalid, 0);
    check("rst_vid_rdv", vid_readdatavalid, 0);
    check("rst_cs", mem_chipselect, 0);
    check("rst_we", mem_write, 0);
    cpu_read = 1'b0; vid_read = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);

    st = cyc; cpu_access(1, 0, 5, 4'hF, 32'hDEADBEEF, acc_c); check("wr_latency", acc_c, st);
    st = cyc; cpu_access(0, 1, 5, 4'hF, 32'h0, acc_c);        check("rd_latency", acc_c, st);
    drain("drain_t1");

    cpu_access(1, 0, 6, 4'hF, 32'h11223344, acc_c);
    cpu_access(1, 0, 6, 4'h1, 32'h000000AA, acc_c);
    cpu_access(0, 1, 6, 4'hF, 32'h0, acc_c);
    drain("drain_bytelane");

    st = cyc; vid_burst(7998, 4, acc_v); check("wrap_burst_latency", acc_v, st);
    drain("drain_wrap");

    st = cyc;
    fork
      cpu_access(0, 1, 100, 4'hF, 32'h0, acc_c);
      vid_burst(200, 4, acc_v);
    join
    check("conflict_vid_first", acc_v, st);
    check("conflict_cpu_after", acc_c, st + 4);
    drain("drain_conflict");

    st = cyc; vid_burst(300, 0, acc_v); check("bc0_latency", acc_v, st);
    drain("drain_bc0");
    st = cyc;
    fork
      cpu_access(0, 1, 101, 4'hF, 32'h0, acc_c);
      vid_burst(400, 31, acc_v);
    join
    check("bc31_cpu_after", acc_c, st + 16);
    drain("drain_bc31");

    st = cyc;
    fork
      begin
        for (int k = 0; k < 5; k++) begin
          vid_burst(1000 + 16 * k, 16, tmp);
          if (k == 0) acc_v0 = tmp;
        end
      end
      cpu_access(0, 1, 102, 4'hF, 32'h0, acc_c);
    join
    check("starve_vid_first", acc_v0, st);
`ifdef FB_ARB_STARVE_GUARD_EN
    check("starve_guard_cpu", acc_c, st + 16);
`else
    check("starve_noguard_cpu", acc_c, st + 80);
`endif
    drain("drain_starve");

    vid_address = AW'(100); vid_burstcount = CW'(16); vid_read = 1'b1;
    #4;
    check("rst_burst_accept", vid_waitrequest, 0);
    for (int i = 0; i < 16; i++) vid_q.push_back('{ref_mem[100 + i], cyc + 1 + i});
    @(negedge clk); vid_read = 1'b0;
    @(negedge clk); @(negedge clk);
    #1 reset_n = 1'b0;
    cpu_read = 1'b1; vid_read = 1'b1;
    #1;
    check("midrst_vid_rdv", vid_readdatavalid, 0);
    check("midrst_cpu_wait", cpu_waitrequest, 1);
    check("midrst_vid_wait", vid_waitrequest, 1);
    check("midrst_cs", mem_chipselect, 0);
    check("midrst_beats_seen", vid_q.size(), 13);
    vid_q.delete();
    repeat (3) @(negedge clk);
    cpu_read = 1'b0; vid_read = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    st = cyc; vid_burst(500, 16, acc_v); check("post_rst_burst", acc_v, st);
    drain("drain_post_rst");

    fork
      begin
        for (int k = 0; k < 150; k++) begin
          int a, rd, wr;
          repeat ($urandom_range(0, 3)) @(negedge clk);
          a  = ($urandom_range(0, 3) == 0) ? $urandom_range(DEPTH - 8, DEPTH - 1) : $urandom_range(0, 63);
          wr = $urandom_range(0, 1);
          rd = wr ? $urandom_range(0, 1) : 1;
          cpu_access(wr[0], rd[0], a, 4'($urandom_range(0, 15)), $urandom, acc_c);
        end
      end
      begin
        for (int k = 0; k < 30; k++) begin
          int a;
          repeat ($urandom_range(0, 6)) @(negedge clk);
          a = ($urandom_range(0, 2) == 0) ? $urandom_range(DEPTH - 20, DEPTH - 1) : $urandom_range(0, 63);
          vid_burst(a, $urandom_range(0, 31), acc_v);
        end
      end
    join
    drain("drain_random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
